// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model: decodes 48-bit command frames from the host and
// answers with R1/R3/R7 responses while tracking the card initialisation state.
module sd_spi_card_responder #(
  parameter int          NCR        = 1,
  parameter int          INIT_POLLS = 3,
  parameter logic [31:0] OCR_VALUE  = 32'h00FF8000,
  parameter logic        CCS        = 1'b1,
  parameter logic        CRC_CHECK  = 1'b1
) (
  input  logic       card_clk_i,
  input  logic       card_rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       card_ready_o,
  output logic       cmd_valid_o,
  output logic [5:0] cmd_index_o,
  output logic       crc_err_o
);

  // state  | meaning
  // S_HUNT | waiting for a start bit with cs_n low
  // S_RX   | shifting in the remaining frame bits
  // S_EVAL | one clk: check CRC, update card state, build response
  // S_GAP  | NCR bytes of 0xFF on MISO
  // S_TX   | response shifted out MSB-first
  typedef enum logic [2:0] {S_HUNT, S_RX, S_EVAL, S_GAP, S_TX} state_t;

  localparam logic [6:0] GAP_BITS = 7'(NCR * 8);

  state_t      state, state_nx;
  logic [1:0]  sck_sync, cs_sync, mosi_sync;
  logic        sck_d, cs_d;
  logic        sck_rise, sck_fall, cs_rise, cs_s, mosi_s;
  logic [47:0] shift_rx;
  logic [5:0]  bit_cnt;
  logic [6:0]  gap_cnt;
  logic [5:0]  tx_cnt, tx_len;
  logic [39:0] resp;
  logic        in_idle, app_cmd, ready;
  logic [3:0]  poll_cnt;
  logic [5:0]  frm_idx;
  logic [31:0] frm_arg;
  logic [6:0]  crc_calc;
  logic        crc_bad;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign sck_rise = sck_sync[1] & ~sck_d;
  assign sck_fall = ~sck_sync[1] & sck_d;
  assign cs_rise  = cs_sync[1] & ~cs_d;
  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];

  assign frm_idx  = shift_rx[45:40];
  assign frm_arg  = shift_rx[39:8];
  assign crc_calc = crc7(shift_rx[47:8]);
  assign crc_bad  = ~shift_rx[0] |
                    (CRC_CHECK && (frm_idx == 6'd0 || frm_idx == 6'd8) &&
                     crc_calc != shift_rx[7:1]);

  assign card_ready_o = ready;

  always_ff @(posedge card_clk_i or posedge card_rst_i) begin
    if (card_rst_i) state <= S_HUNT;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_HUNT: if (sck_rise && !cs_s && !mosi_s) state_nx = S_RX;
      // frames whose transmission bit (46) is not 1 are dropped silently
      S_RX:   if (sck_rise && bit_cnt == 6'd47) state_nx = shift_rx[45] ? S_EVAL : S_HUNT;
      S_EVAL: state_nx = S_GAP;
      S_GAP:  if (sck_fall && gap_cnt == GAP_BITS - 7'd1) state_nx = S_TX;
      S_TX:   if (sck_fall && tx_cnt == tx_len) state_nx = S_HUNT;
      default: state_nx = S_HUNT;
    endcase
    if (cs_rise) state_nx = S_HUNT;
  end

  always_ff @(posedge card_clk_i or posedge card_rst_i) begin
    if (card_rst_i) begin
      sck_sync    <= '0;
      cs_sync     <= 2'b11;
      mosi_sync   <= 2'b11;
      sck_d       <= 1'b0;
      cs_d        <= 1'b1;
      shift_rx    <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_cnt      <= '0;
      tx_len      <= 6'd8;
      resp        <= '0;
      spi_miso_o  <= 1'b1;
      cmd_valid_o <= 1'b0;
      cmd_index_o <= '0;
      crc_err_o   <= 1'b0;
      in_idle     <= 1'b1;
      app_cmd     <= 1'b0;
      ready       <= 1'b0;
      poll_cnt    <= 4'(INIT_POLLS);
    end else begin
      sck_sync    <= {sck_sync[0], spi_sck_i};
      cs_sync     <= {cs_sync[0], spi_cs_n_i};
      mosi_sync   <= {mosi_sync[0], spi_mosi_i};
      sck_d       <= sck_sync[1];
      cs_d        <= cs_sync[1];
      cmd_valid_o <= 1'b0;
      crc_err_o   <= 1'b0;
      if (cs_rise) begin
        bit_cnt    <= '0;
        gap_cnt    <= '0;
        tx_cnt     <= '0;
        spi_miso_o <= 1'b1;
      end else begin
        case (state)
          S_HUNT: if (sck_rise && !cs_s && !mosi_s) begin
            shift_rx <= '0;
            bit_cnt  <= 6'd1;
          end
          S_RX: if (sck_rise) begin
            shift_rx <= {shift_rx[46:0], mosi_s};
            bit_cnt  <= bit_cnt + 6'd1;
          end
          S_EVAL: begin
            cmd_valid_o <= 1'b1;
            cmd_index_o <= frm_idx;
            crc_err_o   <= crc_bad;
            gap_cnt     <= '0;
            tx_cnt      <= '0;
            tx_len      <= 6'd8;
            resp        <= '0;
            if (crc_bad) begin
              resp[39:32] <= {4'b0000, 1'b1, 2'b00, in_idle};
            end else begin
              app_cmd <= 1'b0;
              case (frm_idx)
                6'd0: begin
                  in_idle     <= 1'b1;
                  ready       <= 1'b0;
                  poll_cnt    <= 4'(INIT_POLLS);
                  resp[39:32] <= 8'h01;
                end
                6'd8: begin
                  resp   <= {7'b0, in_idle, 20'h00000, frm_arg[11:0]};
                  tx_len <= 6'd40;
                end
                6'd55: begin
                  app_cmd     <= 1'b1;
                  resp[39:32] <= {7'b0, in_idle};
                end
                6'd41: begin
                  if (!app_cmd) begin
                    resp[39:32] <= {5'b0, 1'b1, 1'b0, in_idle};
                  end else if (poll_cnt > 4'd1) begin
                    poll_cnt    <= poll_cnt - 4'd1;
                    resp[39:32] <= 8'h01;
                  end else begin
                    in_idle     <= 1'b0;
                    ready       <= 1'b1;
                    resp[39:32] <= 8'h00;
                  end
                end
                6'd58: begin
                  resp   <= {7'b0, in_idle, ~in_idle, ~in_idle & CCS, OCR_VALUE[29:0]};
                  tx_len <= 6'd40;
                end
                default: resp[39:32] <= {5'b0, 1'b1, 1'b0, in_idle};
              endcase
            end
          end
          S_GAP: if (sck_fall) begin
            gap_cnt    <= gap_cnt + 7'd1;
            spi_miso_o <= 1'b1;
          end
          S_TX: if (sck_fall) begin
            if (tx_cnt == tx_len) begin
              spi_miso_o <= 1'b1;
            end else begin
              spi_miso_o <= resp[39];
              resp       <= {resp[38:0], 1'b0};
              tx_cnt     <= tx_cnt + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Host-side bench for sd_spi_card_responder: drives SPI command frames and
// checks responses, pulses and card state against a queue of expected results.
module tb_sd_spi_card_responder;

  localparam int NCR = 1;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b1;
  logic       miso;
  logic       card_ready;
  logic       cmd_valid;
  logic [5:0] cmd_index;
  logic       crc_err;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  int crc_cnt   = 0;

  typedef struct {
    int          len;
    logic [39:0] val;
    logic [5:0]  idx;
    int          bad;
  } exp_t;
  exp_t sb[$];

  sd_spi_card_responder #(.NCR(NCR), .INIT_POLLS(3), .OCR_VALUE(32'h00FF8000),
                          .CCS(1'b1), .CRC_CHECK(1'b1)) dut (
    .card_clk_i  (clk),
    .card_rst_i  (rst),
    .spi_sck_i   (sck),
    .spi_cs_n_i  (cs_n),
    .spi_mosi_i  (mosi),
    .spi_miso_o  (miso),
    .card_ready_o(card_ready),
    .cmd_valid_o (cmd_valid),
    .cmd_index_o (cmd_index),
    .crc_err_o   (crc_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid) valid_cnt++;
    if (crc_err)   crc_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [47:0] frm, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = frm[47-i];
      #HALF sck = 1'b1;
      #HALF sck = 1'b0;
    end
    mosi = 1'b1;
  endtask

  task automatic read_resp(input string tag, input int v0, input int c0);
    exp_t        e;
    logic [39:0] val;
    logic [7:0]  gap;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e   = sb.pop_front();
    val = '0;
    gap = '0;
    for (int k = 0; k < 8 * NCR + e.len; k++) begin
      #(HALF - 5);
      if (k < 8 * NCR) gap = {gap[6:0], miso};
      else             val = {val[38:0], miso};
      #5 sck = 1'b1;
      #HALF sck = 1'b0;
    end
    #(HALF - 5);
    check_val({tag, "_idle_miso"}, 64'(miso), 64'd1);
    #5;
    check_val({tag, "_gap"}, 64'(gap), 64'hFF);
    check_val({tag, "_resp"}, 64'(val), 64'(e.val));
    check_val({tag, "_valid"}, 64'(valid_cnt - v0), 64'd1);
    check_val({tag, "_index"}, 64'(cmd_index), 64'(e.idx));
    check_val({tag, "_crcerr"}, 64'(crc_cnt - c0), 64'(e.bad));
  endtask

  task automatic do_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [7:0] last, input int len, input logic [39:0] exp_val,
                        input int bad);
    int   v0, c0;
    exp_t e;
    v0 = valid_cnt;
    c0 = crc_cnt;
    e.len = len; e.val = exp_val; e.idx = idx; e.bad = bad;
    sb.push_back(e);
    send_bits({2'b01, idx, arg, last}, 48);
    read_resp(tag, v0, c0);
    #(2 * HALF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    logic [7:0] acmd_exp [3];
    logic       rdy_exp  [3];
    acmd_exp = '{8'h01, 8'h01, 8'h00};
    rdy_exp  = '{1'b0, 1'b0, 1'b1};

    #52 rst = 1'b0;
    @(negedge clk);
    check_val("rst_miso",  64'(miso), 64'd1);
    check_val("rst_ready", 64'(card_ready), 64'd0);
    check_val("rst_valid", 64'(cmd_valid), 64'd0);
    check_val("rst_index", 64'(cmd_index), 64'd0);
    check_val("rst_crc",   64'(crc_err), 64'd0);
    #48 cs_n = 1'b0;
    #200;

    do_cmd("cmd0",      6'd0,  32'h0,        8'h95, 8,  40'h01, 0);
    do_cmd("cmd8",      6'd8,  32'h000001AA, 8'h87, 40, 40'h01000001AA, 0);
    do_cmd("cmd8_crc",  6'd8,  32'h000001AA, 8'h01, 8,  40'h09, 1);
    do_cmd("cmd58_bsy", 6'd58, 32'h0,        8'h01, 40, 40'h0100FF8000, 0);
    do_cmd("acmd41_na", 6'd41, 32'h40000000, 8'h01, 8,  40'h05, 0);
    do_cmd("cmd17_idl", 6'd17, 32'h0,        8'h01, 8,  40'h05, 0);

    for (int i = 0; i < 3; i++) begin
      do_cmd("cmd55",  6'd55, 32'h0,        8'h01, 8, 40'h01, 0);
      do_cmd("acmd41", 6'd41, 32'h40000000, 8'h01, 8, 40'(acmd_exp[i]), 0);
      check_val("ready_poll", 64'(card_ready), 64'(rdy_exp[i]));
    end

    do_cmd("cmd58_rdy", 6'd58, 32'h0, 8'h01, 40, 40'h00C0FF8000, 0);
    do_cmd("cmd17_rdy", 6'd17, 32'h0, 8'h01, 8,  40'h04, 0);
    do_cmd("end_bit0",  6'd55, 32'h0, 8'h00, 8,  40'h08, 1);

    v0 = valid_cnt;
    send_bits({2'b01, 6'd17, 32'h12345678, 8'h01}, 20);
    cs_n = 1'b1;
    #400;
    check_val("abort_miso", 64'(miso), 64'd1);
    cs_n = 1'b0;
    #200;
    check_val("abort_valid", 64'(valid_cnt - v0), 64'd0);
    do_cmd("cmd0_again", 6'd0, 32'h0, 8'h95, 8, 40'h01, 0);
    check_val("ready_cleared", 64'(card_ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
